// File: rtl/pcache_pkg.sv
// Shared types and helpers for the writable program cache.
package pcache_pkg;

   // Load-side FSM states
   typedef enum logic [2:0] {
      StIdle,
      StHdrN,
      StHdrM,
      StLoadInsn,
      StLoadRo,
      StReady,
      StError
   } pcache_state_t;

   // Instruction returned for any fetch that misses the resident image
   localparam logic [15:0] NOP_INSN = 16'h8000;

   // Number of 16-bit load words needed to carry one {formula, loop} entry
   function automatic int unsigned ro_words(input int unsigned formula_w,
                                            input int unsigned loop_w);
      return (formula_w + loop_w + 15) / 16;
   endfunction

endpackage

// File: rtl/pcache_word_packer.sv
// Shift-in packer turning a stream of 16-bit words into one read-only entry.
// The first word lands in the MSBs; the entry is the top OutW bits of the
// RoWords*16 image. full_o pulses on the cycle the last word is shifted in,
// and entry_o already includes that word so the caller can write it that edge.
module pcache_word_packer #(
   parameter int unsigned RoWords = 53,
   parameter int unsigned OutW    = 840
) (
   input  logic            clk_i,
   input  logic            reset_i,
   input  logic            clear_i,
   input  logic            shift_i,
   input  logic [15:0]     data_i,
   output logic            full_o,
   output logic [OutW-1:0] entry_o
);

   localparam int unsigned PackW = RoWords * 16;
   localparam int unsigned HoldW = PackW - 16;
   localparam int unsigned CntW  = $clog2(RoWords + 1);

   // Holds the first RoWords-1 words; the final word comes straight from data_i
   logic [HoldW-1:0] hold_q;
   logic [CntW-1:0]  cnt_q;
   logic             last;

   assign last    = (cnt_q == CntW'(RoWords - 1));
   assign full_o  = shift_i & last;
   assign entry_o = OutW'({hold_q, data_i} >> (PackW - OutW));

   // Word counter: restarts on clear and wraps after each complete entry
   always_ff @(posedge clk_i or posedge reset_i) begin
      if (reset_i) begin
         cnt_q <= '0;
      end else if (clear_i) begin
         cnt_q <= '0;
      end else if (shift_i) begin
         cnt_q <= last ? '0 : cnt_q + CntW'(1);
      end
   end

   // Data shift register, no reset needed since stale contents are never exposed
   always_ff @(posedge clk_i) begin
      if (shift_i) begin
         hold_q <= {hold_q[HoldW-17:0], data_i};
      end
   end

endmodule

// File: rtl/prog_cache.sv
// Writable program cache: loads an image (header N, M, N instructions,
// M packed read-only entries) over a valid/ready port and serves registered
// instruction and read-only fetches once a complete image is resident.
module prog_cache
   import pcache_pkg::*;
#(
   parameter int unsigned INSN_DEPTH = 64,
   parameter int unsigned RO_DEPTH   = 4,
   parameter int unsigned FORMULA_W  = 648,
   parameter int unsigned LOOP_W     = 192
) (
   input  logic                        clk,
   input  logic                        reset,
   input  logic                        load_start,
   input  logic                        load_valid,
   input  logic [15:0]                 load_data,
   output logic                        load_ready,
   output logic                        loaded,
   output logic                        load_error,
   input  logic [15:0]                 pc,
   output logic [15:0]                 raw_instruction,
   output logic                        insn_valid,
   input  logic [$clog2(RO_DEPTH)-1:0] ro_addr,
   output logic [0:FORMULA_W-1]        prog_apu_formula,
   output logic [LOOP_W-1:0]           prog_loop_ro_data
);

   localparam int unsigned RoWords = ro_words(FORMULA_W, LOOP_W);
   localparam int unsigned EntryW  = FORMULA_W + LOOP_W;
   localparam int unsigned NW      = $clog2(INSN_DEPTH + 1);
   localparam int unsigned MW      = $clog2(RO_DEPTH + 1);
   localparam int unsigned IAW     = (INSN_DEPTH > 1) ? $clog2(INSN_DEPTH) : 1;
   localparam int unsigned RAW     = $clog2(RO_DEPTH);

   pcache_state_t state_q, state_d;

   logic [NW-1:0]     n_q;
   logic [MW-1:0]     m_q;
   logic [NW-1:0]     insn_cnt_q;
   logic [MW-1:0]     ro_cnt_q;
   logic              load_ready_q, loaded_q, load_error_q;

   logic [15:0]       insn_q [INSN_DEPTH];
   logic [EntryW-1:0] ro_q [RO_DEPTH];

   logic [15:0]       raw_q;
   logic              insn_valid_q;
   logic [0:FORMULA_W-1] formula_q;
   logic [LOOP_W-1:0] loop_q;

   logic              accept;
   logic              insn_last, ro_last;
   logic              pack_shift, pack_full;
   logic [EntryW-1:0] pack_entry;
   logic              insn_hit, ro_hit;

   // load_start wins over a simultaneous word, which is dropped
   assign accept     = load_valid & load_ready_q & ~load_start;
   assign insn_last  = ((insn_cnt_q + NW'(1)) == n_q);
   assign ro_last    = ((ro_cnt_q + MW'(1)) == m_q);
   assign pack_shift = accept & (state_q == StLoadRo);

   pcache_word_packer #(
      .RoWords(RoWords),
      .OutW   (EntryW)
   ) u_packer (
      .clk_i  (clk),
      .reset_i(reset),
      .clear_i(load_start),
      .shift_i(pack_shift),
      .data_i (load_data),
      .full_o (pack_full),
      .entry_o(pack_entry)
   );

   // Next-state decode driven by load_start and accepted words
   always_comb begin
      state_d = state_q;
      if (load_start) begin
         state_d = StHdrN;
      end else if (accept) begin
         case (state_q)
            StHdrN: state_d = (load_data > 16'(INSN_DEPTH)) ? StError : StHdrM;
            StHdrM: begin
               if (load_data > 16'(RO_DEPTH)) begin
                  state_d = StError;
               end else if (n_q == '0) begin
                  state_d = (load_data == '0) ? StReady : StLoadRo;
               end else begin
                  state_d = StLoadInsn;
               end
            end
            StLoadInsn: if (insn_last) state_d = (m_q == '0) ? StReady : StLoadRo;
            StLoadRo:   if (pack_full && ro_last) state_d = StReady;
            default:    state_d = state_q;
         endcase
      end
   end

   // Load FSM with header/counter registers and registered status outputs
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q      <= StIdle;
         n_q          <= '0;
         m_q          <= '0;
         insn_cnt_q   <= '0;
         ro_cnt_q     <= '0;
         load_ready_q <= 1'b0;
         loaded_q     <= 1'b0;
         load_error_q <= 1'b0;
      end else begin
         state_q      <= state_d;
         load_ready_q <= (state_d == StHdrN) || (state_d == StHdrM) ||
                         (state_d == StLoadInsn) || (state_d == StLoadRo);
         loaded_q     <= (state_d == StReady);
         load_error_q <= (state_d == StError);
         if (load_start) begin
            insn_cnt_q <= '0;
            ro_cnt_q   <= '0;
         end else if (accept) begin
            case (state_q)
               StHdrN:     n_q <= load_data[NW-1:0];
               StHdrM:     m_q <= load_data[MW-1:0];
               StLoadInsn: insn_cnt_q <= insn_cnt_q + NW'(1);
               StLoadRo:   if (pack_full) ro_cnt_q <= ro_cnt_q + MW'(1);
               default:    ;
            endcase
         end
      end
   end

   // Storage writes; contents deliberately survive reset and reloads
   always_ff @(posedge clk) begin
      if (accept && (state_q == StLoadInsn)) begin
         insn_q[insn_cnt_q[IAW-1:0]] <= load_data;
      end
      if (pack_full) begin
         ro_q[ro_cnt_q[RAW-1:0]] <= pack_entry;
      end
   end

   // pc < N <= INSN_DEPTH keeps the truncated index in range on a hit
   assign insn_hit = loaded_q && (pc < 16'(n_q));
   assign ro_hit   = loaded_q && (MW'(ro_addr) < m_q);

   // Registered fetch ports, one-cycle latency
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         raw_q        <= NOP_INSN;
         insn_valid_q <= 1'b0;
         formula_q    <= '0;
         loop_q       <= '0;
      end else begin
         if (insn_hit) begin
            raw_q        <= insn_q[pc[IAW-1:0]];
            insn_valid_q <= 1'b1;
         end else begin
            raw_q        <= NOP_INSN;
            insn_valid_q <= 1'b0;
         end
         if (ro_hit) begin
            formula_q <= ro_q[ro_addr][EntryW-1 -: FORMULA_W];
            loop_q    <= ro_q[ro_addr][LOOP_W-1:0];
         end else begin
            formula_q <= '0;
            loop_q    <= '0;
         end
      end
   end

   assign load_ready        = load_ready_q;
   assign loaded            = loaded_q;
   assign load_error        = load_error_q;
   assign raw_instruction   = raw_q;
   assign insn_valid        = insn_valid_q;
   assign prog_apu_formula  = formula_q;
   assign prog_loop_ro_data = loop_q;

endmodule

// File: tb/tb_prog_cache.sv
// Self-checking bench for prog_cache: a reference image model feeds a
// scoreboard queue of expected fetch results, compared one cycle later.
module tb_prog_cache;

   localparam int unsigned ID = 64;
   localparam int unsigned RD = 4;
   localparam int unsigned FW = 648;
   localparam int unsigned LW = 192;
   localparam int unsigned RW = 53;
   localparam logic [15:0] NOP = 16'h8000;

   logic          clk = 1'b0;
   logic          reset;
   logic          load_start, load_valid;
   logic [15:0]   load_data;
   logic          load_ready, loaded, load_error;
   logic [15:0]   pc;
   logic [15:0]   raw_instruction;
   logic          insn_valid;
   logic [1:0]    ro_addr;
   logic [0:FW-1] prog_apu_formula;
   logic [LW-1:0] prog_loop_ro_data;

   int n_checks = 0;
   int n_errors = 0;

   typedef struct {
      string         tag;
      logic [15:0]   raw;
      logic          vld;
      logic [FW-1:0] f;
      logic [LW-1:0] l;
   } exp_t;
   exp_t sb[$];

   // Reference model of the resident image
   logic [15:0]   m_insn [ID];
   logic [FW-1:0] m_f [RD];
   logic [LW-1:0] m_l [RD];
   int            m_n = 0;
   int            m_m = 0;
   bit            m_loaded = 1'b0;

   // Staged image for the next load
   logic [15:0]   ins_img [ID];
   logic [15:0]   ro_img [RD][RW];
   logic [FW-1:0] st_f [RD];
   logic [LW-1:0] st_l [RD];

   prog_cache #(
      .INSN_DEPTH(ID),
      .RO_DEPTH  (RD),
      .FORMULA_W (FW),
      .LOOP_W    (LW)
   ) dut (
      .clk              (clk),
      .reset            (reset),
      .load_start       (load_start),
      .load_valid       (load_valid),
      .load_data        (load_data),
      .load_ready       (load_ready),
      .loaded           (loaded),
      .load_error       (load_error),
      .pc               (pc),
      .raw_instruction  (raw_instruction),
      .insn_valid       (insn_valid),
      .ro_addr          (ro_addr),
      .prog_apu_formula (prog_apu_formula),
      .prog_loop_ro_data(prog_loop_ro_data)
   );

   always #5 clk = ~clk;

   initial begin
      #1000000;
      $display("FAIL watchdog: got timeout, expected finish");
      $fatal(1, "watchdog expired");
   end

   task automatic check(input string tag, input logic [1023:0] got, input logic [1023:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Random RO entry j; expected entry is the top FW+LW bits, first word at the MSB
   task automatic gen_ro(input int j);
      logic [RW*16-1:0] pk;
      logic [FW+LW-1:0] e;
      pk = '0;
      for (int w = 0; w < RW; w++) begin
         ro_img[j][w] = 16'($urandom);
         pk = {pk[RW*16-17:0], ro_img[j][w]};
      end
      e = pk[RW*16-1 -: FW+LW];
      st_f[j] = e[FW+LW-1:LW];
      st_l[j] = e[LW-1:0];
   endtask

   task automatic send_word(input logic [15:0] w, input bit rnd);
      int guard;
      guard = 0;
      if (rnd) begin
         repeat ($urandom_range(0, 3)) begin
            load_valid = 1'b0;
            load_data  = 16'($urandom);
            tick();
         end
      end
      load_valid = 1'b1;
      load_data  = w;
      while (!load_ready && guard < 20) begin
         tick();
         guard++;
      end
      if (!load_ready) check("ready_timeout", load_ready, 1);
      tick();
      load_valid = 1'b0;
      load_data  = 16'($urandom);
   endtask

   task automatic load_image(input int n, input int m, input bit rnd, input bit do_start,
                             input string tag);
      if (do_start) begin
         load_start = 1'b1;
         load_valid = 1'b0;
         tick();
         load_start = 1'b0;
      end
      m_loaded = 1'b0;
      check({tag, "_ready_hdr"}, load_ready, 1);
      send_word(16'(n), rnd);
      check({tag, "_loaded_mid"}, loaded, 0);
      send_word(16'(m), rnd);
      for (int i = 0; i < n; i++) send_word(ins_img[i], rnd);
      for (int j = 0; j < m; j++)
         for (int w = 0; w < RW; w++) send_word(ro_img[j][w], rnd);
      check({tag, "_loaded"}, loaded, 1);
      m_n = n;
      m_m = m;
      for (int i = 0; i < n; i++) m_insn[i] = ins_img[i];
      for (int j = 0; j < m; j++) begin
         m_f[j] = st_f[j];
         m_l[j] = st_l[j];
      end
      m_loaded = 1'b1;
   endtask

   // Drive a fetch, push the model's expectation, compare after the next edge
   task automatic read(input int p, input int a, input string tag);
      exp_t e, g;
      e.tag = tag;
      e.vld = m_loaded && (p < m_n);
      e.raw = NOP;
      if (e.vld) e.raw = m_insn[p];
      e.f = '0;
      e.l = '0;
      if (m_loaded && (a < m_m)) begin
         e.f = m_f[a];
         e.l = m_l[a];
      end
      pc      = 16'(p);
      ro_addr = 2'(a);
      sb.push_back(e);
      tick();
      g = sb.pop_front();
      check({g.tag, "_raw"}, raw_instruction, g.raw);
      check({g.tag, "_vld"}, insn_valid, g.vld);
      check({g.tag, "_formula"}, prog_apu_formula, g.f);
      check({g.tag, "_loop"}, prog_loop_ro_data, g.l);
   endtask

   initial begin
      reset      = 1'b1;
      load_start = 1'b0;
      load_valid = 1'b0;
      load_data  = '0;
      pc         = 16'd7;
      ro_addr    = '0;
      repeat (3) tick();
      reset = 1'b0;

      // Reset state
      check("rst_loaded", loaded, 0);
      check("rst_ready", load_ready, 0);
      check("rst_error", load_error, 0);
      check("rst_raw", raw_instruction, NOP);
      check("rst_vld", insn_valid, 0);
      check("rst_formula", prog_apu_formula, 0);
      check("rst_loop", prog_loop_ro_data, 0);
      read(7, 0, "rst_pc7");

      // Basic N=7, M=1 image
      ins_img[0] = 16'hf000; ins_img[1] = 16'h4080; ins_img[2] = 16'h2000;
      ins_img[3] = 16'h8000; ins_img[4] = 16'h0180; ins_img[5] = 16'h6120;
      ins_img[6] = 16'hc000;
      gen_ro(0);
      load_image(7, 1, 1'b0, 1'b1, "img7");
      read(1, 0, "img7_pc1");
      read(7, 0, "img7_pc7");
      for (int i = 0; i < 7; i++) read(i, 0, "img7_all");
      read(0, 1, "img7_ro_oob");
      read(64, 3, "img7_pc64");

      // Oversized N header
      load_start = 1'b1;
      tick();
      load_start = 1'b0;
      m_loaded = 1'b0;
      send_word(16'(ID + 1), 1'b0);
      check("errn_error", load_error, 1);
      check("errn_ready", load_ready, 0);
      check("errn_loaded", loaded, 0);
      read(1, 0, "errn_fetch");
      load_start = 1'b1;
      tick();
      load_start = 1'b0;
      check("errn_restart_error", load_error, 0);
      check("errn_restart_ready", load_ready, 1);

      // Oversized M header after a valid N
      send_word(16'd1, 1'b0);
      send_word(16'(RD + 1), 1'b0);
      check("errm_error", load_error, 1);
      check("errm_ready", load_ready, 0);

      // Load with random valid gaps
      for (int i = 0; i < 12; i++) ins_img[i] = 16'($urandom);
      for (int j = 0; j < 3; j++) gen_ro(j);
      load_image(12, 3, 1'b1, 1'b1, "rnd");
      for (int i = 0; i < 13; i++) read(i, i % 4, "rnd_fetch");

      // Reset after three instruction words, then full reload
      for (int i = 0; i < 10; i++) ins_img[i] = 16'($urandom);
      gen_ro(1);
      load_start = 1'b1;
      tick();
      load_start = 1'b0;
      m_loaded = 1'b0;
      send_word(16'd10, 1'b0);
      send_word(16'd2, 1'b0);
      for (int i = 0; i < 3; i++) send_word(ins_img[i], 1'b0);
      check("rstmid_ready_pre", load_ready, 1);
      #2 reset = 1'b1;
      #1;
      check("rstmid_ready", load_ready, 0);
      check("rstmid_loaded", loaded, 0);
      tick();
      reset = 1'b0;
      read(0, 0, "rstmid_fetch");
      check("rstmid_idle_ready", load_ready, 0);
      gen_ro(0);
      load_image(10, 2, 1'b0, 1'b1, "reload");
      for (int i = 8; i < 11; i++) read(i, i - 8, "reload_fetch");

      // load_start with a simultaneous word: word dropped, FSM restarts
      load_start = 1'b1;
      load_valid = 1'b1;
      load_data  = 16'd3;
      tick();
      load_start = 1'b0;
      load_valid = 1'b0;
      for (int i = 0; i < 5; i++) ins_img[i] = 16'($urandom);
      gen_ro(2);
      gen_ro(3);
      load_image(5, 4, 1'b0, 1'b0, "simul");
      read(4, 3, "simul_fetch");
      read(5, 2, "simul_fetch_oob");

      // Empty image
      load_image(0, 0, 1'b0, 1'b1, "empty");
      read(0, 0, "empty_pc0");
      read(1, 1, "empty_pc1");
      read(5, 3, "empty_pc5");

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
